// File: rtl/microseq_next_state_pkg.sv
// Shared definitions for the microprogram sequencer: next-state op encodings,
// default address width and the fetch restart address.
package microseq_next_state_pkg;

  typedef logic [2:0] ns_op_t;

  localparam ns_op_t NS_INC   = 3'b000;
  localparam ns_op_t NS_JUMP  = 3'b001;
  localparam ns_op_t NS_DISP  = 3'b010;
  localparam ns_op_t NS_CJUMP = 3'b011;
  localparam ns_op_t NS_CALL  = 3'b100;
  localparam ns_op_t NS_RET   = 3'b101;
  localparam ns_op_t NS_CWAIT = 3'b110;
  localparam ns_op_t NS_ZERO  = 3'b111;

  localparam int AW_DEFAULT = 8;
  localparam int RESET_ADDR = 0;

endpackage

// File: rtl/microseq_next_state_if.sv
// Sequencer bus: control word / decoder inputs in, ROM address and stack flags out.
interface microseq_next_state_if #(
  parameter int AW = 8
);
  import microseq_next_state_pkg::*;

  ns_op_t          ns_op;
  logic [AW-1:0]   cr_addr;
  logic [AW-1:0]   dec_addr;
  logic            cond;
  logic            hold;
  logic [AW-1:0]   state;
  logic [AW-1:0]   inc_q;
  logic            stk_ovf;
  logic            stk_unf;

  modport master (
    output ns_op, cr_addr, dec_addr, cond, hold,
    input  state, inc_q, stk_ovf, stk_unf
  );

  modport slave (
    input  ns_op, cr_addr, dec_addr, cond, hold,
    output state, inc_q, stk_ovf, stk_unf
  );
endinterface

// File: rtl/microseq_next_state_ret_stack.sv
// Return-address LIFO for microsubroutine calls; top entry is read combinationally.
module micro_ret_stack #(
  parameter int AW          = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] dout,
  output logic          full,
  output logic          empty
);
  localparam int SPW = $clog2(STACK_DEPTH);

  logic [AW-1:0]  r_mem [STACK_DEPTH];
  logic [SPW:0]   r_sp;
  logic [SPW-1:0] w_top;

  // Low bits wrap to the last slot when full, which is exactly entry sp-1.
  assign w_top = r_sp[SPW-1:0] - SPW'(1);
  assign dout  = r_mem[w_top];
  assign full  = (r_sp == (SPW+1)'(STACK_DEPTH));
  assign empty = (r_sp == '0);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_sp <= '0;
    end else if (push && !full) begin
      r_sp <= r_sp + (SPW+1)'(1);
    end else if (pop && !empty) begin
      r_sp <= r_sp - (SPW+1)'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (push && !full && !RESET) begin
      r_mem[r_sp[SPW-1:0]] <= din;
    end
  end
endmodule

// File: rtl/microseq_next_state.sv
// Microprogram sequencer: selects and registers the next control state each cycle,
// keeping state+1 in a companion register and subroutine returns on a small stack.
module microseq_next_state
  import microseq_next_state_pkg::*;
#(
  parameter int AW          = AW_DEFAULT,
  parameter int STACK_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  microseq_next_state_if.slave  bus
);
  logic [AW-1:0] r_state;
  logic [AW-1:0] r_inc_q;
  logic          r_stk_ovf;
  logic          r_stk_unf;

  logic [AW-1:0] w_ns;
  logic          w_push;
  logic          w_pop;
  logic          w_ovf_set;
  logic          w_unf_set;
  logic [AW-1:0] w_stk_top;
  logic          w_stk_full;
  logic          w_stk_empty;

  micro_ret_stack #(
    .AW          (AW),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .CLK   (CLK),
    .RESET (RESET),
    .push  (w_push && !bus.hold),
    .pop   (w_pop && !bus.hold),
    .din   (r_inc_q),
    .dout  (w_stk_top),
    .full  (w_stk_full),
    .empty (w_stk_empty)
  );

  always_comb begin
    w_ns      = r_inc_q;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_ovf_set = 1'b0;
    w_unf_set = 1'b0;
    case (bus.ns_op)
      NS_INC:   w_ns = r_inc_q;
      NS_JUMP:  w_ns = bus.cr_addr;
      NS_DISP:  w_ns = bus.dec_addr;
      NS_CJUMP: w_ns = bus.cond ? bus.cr_addr : r_inc_q;
      NS_CALL: begin
        w_ns = bus.cr_addr;
        // A full stack still takes the jump; the lost return is flagged instead.
        if (w_stk_full) w_ovf_set = 1'b1;
        else            w_push    = 1'b1;
      end
      NS_RET: begin
        if (w_stk_empty) begin
          w_ns      = AW'(RESET_ADDR);
          w_unf_set = 1'b1;
        end else begin
          w_ns  = w_stk_top;
          w_pop = 1'b1;
        end
      end
      NS_CWAIT: w_ns = bus.cond ? r_inc_q : r_state;
      NS_ZERO:  w_ns = AW'(RESET_ADDR);
      default:  w_ns = r_inc_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= AW'(RESET_ADDR);
      r_inc_q   <= AW'(RESET_ADDR) + AW'(1);
      r_stk_ovf <= 1'b0;
      r_stk_unf <= 1'b0;
    end else if (!bus.hold) begin
      r_state   <= w_ns;
      r_inc_q   <= w_ns + AW'(1);
      r_stk_ovf <= r_stk_ovf | w_ovf_set;
      r_stk_unf <= r_stk_unf | w_unf_set;
    end
  end

  assign bus.state   = r_state;
  assign bus.inc_q   = r_inc_q;
  assign bus.stk_ovf = r_stk_ovf;
  assign bus.stk_unf = r_stk_unf;
endmodule
